// File: rtl/ppu_reg_ppustatus.sv
// PPUSTATUS (0x2002): VBlank / sprite-0 hit / overflow flags, clear-on-read VBlank with
// the read-vs-set race window, write-toggle clear pulse and the active-low NMI output.
module ppu_reg_ppustatus #(
    parameter int NMI_SUPPRESS_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ppustatus_read_en,
    input  logic [7:0] open_bus_in,
    input  logic       vblank_set,
    input  logic       prerender_clear,
    input  logic       sprite0_hit_set,
    input  logic       sprite_overflow_set,
    input  logic       nmi_enable,
    output logic [7:0] ppustatus_out,
    output logic       write_toggle_clear,
    output logic       vblank_flag,
    output logic       nmi_n,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(NMI_SUPPRESS_CYCLES + 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_FRESH      = 2'd1;
    localparam logic [1:0] S_SET        = 2'd2;
    localparam logic [1:0] S_SUPPRESSED = 2'd3;

    generate
        if (NMI_SUPPRESS_CYCLES < 1) begin : g_bad_param
            $error("NMI_SUPPRESS_CYCLES must be at least 1");
        end
    endgenerate

    // Strobe semantics: ppustatus_read_en is a one-cycle pulse with no back-pressure; the
    // captured value appears on ppustatus_out the next cycle together with a one-cycle
    // write_toggle_clear pulse, and stays until the following read.
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_sprite0_hit;
    logic          r_overflow;
    logic          w_vblank;
    logic [CW-1:0] w_cnt_last;

    assign w_cnt_last  = CW'(NMI_SUPPRESS_CYCLES - 1);
    assign w_vblank    = (r_state == S_FRESH) || (r_state == S_SET);
    assign vblank_flag = w_vblank;
    assign dbg_state   = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (prerender_clear) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (vblank_set && ppustatus_read_en) begin
                        w_state_nxt = S_SUPPRESSED;
                    end else if (vblank_set) begin
                        w_state_nxt = S_FRESH;
                        w_cnt_nxt   = '0;
                    end
                end
                S_FRESH: begin
                    // A read inside the race window cancels this frame's NMI entirely.
                    if (ppustatus_read_en) begin
                        w_state_nxt = S_SUPPRESSED;
                    end else if (r_cnt == w_cnt_last) begin
                        w_state_nxt = S_SET;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_SET: begin
                    if (ppustatus_read_en) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_SUPPRESSED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_sprite0_hit      <= 1'b0;
            r_overflow         <= 1'b0;
            ppustatus_out      <= 8'h00;
            write_toggle_clear <= 1'b0;
            nmi_n              <= 1'b1;
        end else begin
            r_state            <= w_state_nxt;
            r_cnt              <= w_cnt_nxt;
            write_toggle_clear <= ppustatus_read_en;
            nmi_n              <= ~(nmi_enable && (w_state_nxt == S_SET));

            if (prerender_clear) begin
                r_sprite0_hit <= 1'b0;
                r_overflow    <= 1'b0;
            end else begin
                if (sprite0_hit_set)     r_sprite0_hit <= 1'b1;
                if (sprite_overflow_set) r_overflow    <= 1'b1;
            end

            if (ppustatus_read_en) begin
                ppustatus_out <= {w_vblank, r_sprite0_hit, r_overflow, open_bus_in[4:0]};
            end
        end
    end

endmodule

// File: tb/tb_ppu_reg_ppustatus.sv
// Directed bench for ppu_reg_ppustatus: reset, read capture, VBlank/NMI timing, race window,
// sticky sprite flags, NMI enable gating, priority of prerender_clear and back-to-back reads.
module tb_ppu_reg_ppustatus;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ppustatus_read_en;
    logic [7:0] open_bus_in;
    logic       vblank_set;
    logic       prerender_clear;
    logic       sprite0_hit_set;
    logic       sprite_overflow_set;
    logic       nmi_enable;
    logic [7:0] ppustatus_out;
    logic       write_toggle_clear;
    logic       vblank_flag;
    logic       nmi_n;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ppu_reg_ppustatus #(.NMI_SUPPRESS_CYCLES(2)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ppustatus_read_en   (ppustatus_read_en),
        .open_bus_in         (open_bus_in),
        .vblank_set          (vblank_set),
        .prerender_clear     (prerender_clear),
        .sprite0_hit_set     (sprite0_hit_set),
        .sprite_overflow_set (sprite_overflow_set),
        .nmi_enable          (nmi_enable),
        .ppustatus_out       (ppustatus_out),
        .write_toggle_clear  (write_toggle_clear),
        .vblank_flag         (vblank_flag),
        .nmi_n               (nmi_n),
        .dbg_state           (dbg_state)
    );

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        ppustatus_read_en   = 1'b0;
        vblank_set          = 1'b0;
        prerender_clear     = 1'b0;
        sprite0_hit_set     = 1'b0;
        sprite_overflow_set = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; nmi_enable = 1'b0; open_bus_in = 8'h00; clear_pulses();
        tick(); tick();
        checks++; if (ppustatus_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", ppustatus_out); end
        checks++; if (write_toggle_clear !== 1'b0) begin errors++; $display("FAIL reset_wtc got %b want 0", write_toggle_clear); end
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL reset_nmi got %b want 1", nmi_n); end
        checks++; if (vblank_flag !== 1'b0) begin errors++; $display("FAIL reset_vblank got %b want 0", vblank_flag); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_idle();
        open_bus_in = 8'h1F; ppustatus_read_en = 1'b1;
        tick(); clear_pulses();
        checks++; if (ppustatus_out !== 8'h1F) begin errors++; $display("FAIL idle_read_out got %h want 1f", ppustatus_out); end
        checks++; if (write_toggle_clear !== 1'b1) begin errors++; $display("FAIL idle_read_wtc got %b want 1", write_toggle_clear); end
        open_bus_in = 8'h00;
        tick();
        checks++; if (write_toggle_clear !== 1'b0) begin errors++; $display("FAIL idle_wtc_pulse got %b want 0", write_toggle_clear); end
        checks++; if (ppustatus_out !== 8'h1F) begin errors++; $display("FAIL idle_out_held got %h want 1f", ppustatus_out); end
    endtask

    task automatic test_vblank_nmi();
        nmi_enable = 1'b1; open_bus_in = 8'hEA;
        vblank_set = 1'b1;
        tick(); clear_pulses();
        checks++; if (vblank_flag !== 1'b1) begin errors++; $display("FAIL vb_flag_set got %b want 1", vblank_flag); end
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL vb_nmi_c0 got %b want 1", nmi_n); end
        tick();
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL vb_nmi_c1 got %b want 1", nmi_n); end
        tick();
        checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL vb_nmi_c2 got %b want 0", nmi_n); end
        tick(); tick();
        checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL vb_nmi_c4 got %b want 0", nmi_n); end
        ppustatus_read_en = 1'b1;
        tick(); clear_pulses();
        checks++; if (ppustatus_out !== 8'h8A) begin errors++; $display("FAIL vb_read_out got %h want 8a", ppustatus_out); end
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL vb_read_nmi got %b want 1", nmi_n); end
        checks++; if (vblank_flag !== 1'b0) begin errors++; $display("FAIL vb_read_flag got %b want 0", vblank_flag); end
        checks++; if (write_toggle_clear !== 1'b1) begin errors++; $display("FAIL vb_read_wtc got %b want 1", write_toggle_clear); end
        open_bus_in = 8'h00;
    endtask

    task automatic test_race_same_cycle();
        nmi_enable = 1'b1;
        vblank_set = 1'b1; ppustatus_read_en = 1'b1;
        tick(); clear_pulses();
        checks++; if (ppustatus_out[7] !== 1'b0) begin errors++; $display("FAIL race_bit7 got %b want 0", ppustatus_out[7]); end
        checks++; if (dbg_state !== 2'd3) begin errors++; $display("FAIL race_state got %0d want 3", dbg_state); end
        tick(); tick(); tick();
        checks++; if (nmi_n !== 1'b1 || vblank_flag !== 1'b0) begin errors++; $display("FAIL race_hold got nmi_n=%b vb=%b want 1/0", nmi_n, vblank_flag); end
        vblank_set = 1'b1;
        tick(); clear_pulses();
        checks++; if (vblank_flag !== 1'b0) begin errors++; $display("FAIL race_reset_ignored got %b want 0", vblank_flag); end
        prerender_clear = 1'b1;
        tick(); clear_pulses();
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL race_prerender got %0d want 0", dbg_state); end
    endtask

    task automatic test_read_fresh();
        nmi_enable = 1'b1; open_bus_in = 8'h00;
        vblank_set = 1'b1;
        tick(); clear_pulses();
        ppustatus_read_en = 1'b1;
        tick(); clear_pulses();
        checks++; if (ppustatus_out !== 8'h80) begin errors++; $display("FAIL fresh_read_out got %h want 80", ppustatus_out); end
        checks++; if (vblank_flag !== 1'b0) begin errors++; $display("FAIL fresh_read_flag got %b want 0", vblank_flag); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL fresh_nmi_c%0d got %b want 1", i, nmi_n); end
        end
        vblank_set = 1'b1;
        tick(); clear_pulses();
        checks++; if (vblank_flag !== 1'b0) begin errors++; $display("FAIL fresh_second_vb got %b want 0", vblank_flag); end
        prerender_clear = 1'b1;
        tick(); clear_pulses();
    endtask

    task automatic test_sprite_flags();
        open_bus_in = 8'h00;
        sprite0_hit_set = 1'b1;
        tick(); clear_pulses();
        sprite_overflow_set = 1'b1;
        tick(); clear_pulses();
        ppustatus_read_en = 1'b1;
        tick(); clear_pulses();
        checks++; if (ppustatus_out[6:5] !== 2'b11) begin errors++; $display("FAIL spr_read1 got %b want 11", ppustatus_out[6:5]); end
        ppustatus_read_en = 1'b1;
        tick(); clear_pulses();
        checks++; if (ppustatus_out[6:5] !== 2'b11) begin errors++; $display("FAIL spr_read2 got %b want 11", ppustatus_out[6:5]); end
        prerender_clear = 1'b1;
        tick(); clear_pulses();
        ppustatus_read_en = 1'b1;
        tick(); clear_pulses();
        checks++; if (ppustatus_out[6:5] !== 2'b00) begin errors++; $display("FAIL spr_cleared got %b want 00", ppustatus_out[6:5]); end
        sprite0_hit_set = 1'b1; sprite_overflow_set = 1'b1; prerender_clear = 1'b1;
        tick(); clear_pulses();
        ppustatus_read_en = 1'b1;
        tick(); clear_pulses();
        checks++; if (ppustatus_out[6:5] !== 2'b00) begin errors++; $display("FAIL spr_clear_wins got %b want 00", ppustatus_out[6:5]); end
    endtask

    task automatic test_nmi_enable();
        nmi_enable = 1'b0; open_bus_in = 8'h1F;
        ppustatus_read_en = 1'b1;
        tick(); clear_pulses();
        vblank_set = 1'b1;
        tick(); clear_pulses();
        tick(); tick();
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL en_state got %0d want 2", dbg_state); end
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL en_off_nmi got %b want 1", nmi_n); end
        nmi_enable = 1'b1;
        tick();
        checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL en_rise_nmi got %b want 0", nmi_n); end
        nmi_enable = 1'b0;
        tick();
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL en_fall_nmi got %b want 1", nmi_n); end
        nmi_enable = 1'b1;
        tick();
        checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL en_rise2_nmi got %b want 0", nmi_n); end
        rst_n = 1'b0;
        tick();
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL midrst_nmi got %b want 1", nmi_n); end
        checks++; if (ppustatus_out !== 8'h00) begin errors++; $display("FAIL midrst_out got %h want 00", ppustatus_out); end
        checks++; if (vblank_flag !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_state got vb=%b st=%0d want 0/0", vblank_flag, dbg_state); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_prerender_priority();
        nmi_enable = 1'b1; open_bus_in = 8'h05;
        vblank_set = 1'b1;
        tick(); clear_pulses();
        tick(); tick();
        checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL pri_nmi_low got %b want 0", nmi_n); end
        prerender_clear = 1'b1; ppustatus_read_en = 1'b1; vblank_set = 1'b1;
        tick(); clear_pulses();
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL pri_state got %0d want 0", dbg_state); end
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL pri_nmi got %b want 1", nmi_n); end
        checks++; if (ppustatus_out !== 8'h85) begin errors++; $display("FAIL pri_out got %h want 85", ppustatus_out); end
    endtask

    task automatic test_back_to_back();
        open_bus_in = 8'h03; ppustatus_read_en = 1'b1;
        tick();
        checks++; if (ppustatus_out !== 8'h03) begin errors++; $display("FAIL b2b_first got %h want 03", ppustatus_out); end
        open_bus_in = 8'hF5;
        tick(); clear_pulses();
        checks++; if (ppustatus_out !== 8'h15) begin errors++; $display("FAIL b2b_second got %h want 15", ppustatus_out); end
        checks++; if (write_toggle_clear !== 1'b1) begin errors++; $display("FAIL b2b_wtc got %b want 1", write_toggle_clear); end
        tick();
        checks++; if (write_toggle_clear !== 1'b0) begin errors++; $display("FAIL b2b_wtc_end got %b want 0", write_toggle_clear); end
    endtask

    initial begin
        test_reset();
        test_read_idle();
        test_vblank_nmi();
        test_race_same_cycle();
        test_read_fresh();
        test_sprite_flags();
        test_nmi_enable();
        test_prerender_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
